atm_bank_responder: RTL and testbench

//  Bank-side responder for the ATM controller: owns the account table (number, PIN, balance, PIN-fail count)
//  and services one transaction at a time over a valid/ready request/response pair. Checks PINs,

---
 rtl/atm_bank_responder.sv | 210 +++++++++++++++++++++
 tb/tb_atm_bank_responder.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/atm_bank_responder.sv
// Bank-side account table and transaction engine for the ATM controller.
// One transaction at a time: linear search of the table, one execute cycle, then a held response.
module atm_bank_responder #(
    parameter int NUM_ACCTS     = 3,
    parameter int REG_WIDTH     = 12,
    parameter int AMT_WIDTH     = 6,
    parameter int MAX_PIN_FAILS = 3,
    localparam int IDX_W        = (NUM_ACCTS > 1) ? $clog2(NUM_ACCTS) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 init_we,
    input  logic [IDX_W-1:0]     init_idx,
    input  logic [REG_WIDTH-1:0] init_acct,
    input  logic [REG_WIDTH-1:0] init_pin,
    input  logic [REG_WIDTH-1:0] init_balance,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [2:0]           req_op,
    input  logic [REG_WIDTH-1:0] req_acct,
    input  logic [REG_WIDTH-1:0] req_pin,
    input  logic [REG_WIDTH-1:0] req_dst,
    input  logic [AMT_WIDTH-1:0] req_amount,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [2:0]           rsp_status,
    output logic [REG_WIDTH-1:0] rsp_balance,
    output logic [REG_WIDTH-1:0] rsp_dst_balance
);

    localparam logic [2:0] OP_LOOKUP = 3'd0, OP_DEPOSIT = 3'd3,
                           OP_WITHDRAW = 3'd4, OP_TRANSFER = 3'd5;
    localparam logic [2:0] ST_OK = 3'd0, ST_NO_ACCT = 3'd1, ST_BAD_PIN = 3'd2, ST_LOCKED = 3'd3,
                           ST_INSUFF = 3'd4, ST_NO_DST = 3'd5, ST_OVERFLOW = 3'd6, ST_BAD_REQ = 3'd7;
    localparam logic [1:0]       FAIL_MAX = 2'(MAX_PIN_FAILS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ACCTS - 1);

    typedef enum logic [1:0] {S_IDLE, S_SEARCH, S_EXEC, S_RESP} state_t;

    state_t               state_q;
    logic                 tbl_vld_q  [NUM_ACCTS];
    logic [REG_WIDTH-1:0] tbl_acct_q [NUM_ACCTS];
    logic [REG_WIDTH-1:0] tbl_pin_q  [NUM_ACCTS];
    logic [REG_WIDTH-1:0] tbl_bal_q  [NUM_ACCTS];
    logic [1:0]           tbl_fail_q [NUM_ACCTS];

    logic [2:0]           rq_op_q;
    logic [REG_WIDTH-1:0] rq_acct_q, rq_pin_q, rq_dst_q;
    logic [AMT_WIDTH-1:0] rq_amt_q;
    logic [IDX_W-1:0]     idx_q, src_idx_q, dst_idx_q;
    logic                 src_hit_q, dst_hit_q;

    logic                 rsp_valid_q;
    logic [2:0]           rsp_status_q;
    logic [REG_WIDTH-1:0] rsp_bal_q, rsp_dbal_q;

    logic [2:0]           status_d;
    logic [REG_WIDTH-1:0] src_bal, dst_bal, amt_ext, src_bal_d, dst_bal_d;
    logic [REG_WIDTH:0]   src_sum, dst_sum;
    logic                 wr_src, wr_dst, fail_clr, fail_inc;

    assign req_ready       = (state_q == S_IDLE) & ~init_we;
    assign rsp_valid       = rsp_valid_q;
    assign rsp_status      = rsp_status_q;
    assign rsp_balance     = rsp_bal_q;
    assign rsp_dst_balance = rsp_dbal_q;

    // Execute-cycle decision; only OK outcomes raise a balance write.
    always_comb begin
        src_bal   = tbl_bal_q[src_idx_q];
        dst_bal   = tbl_bal_q[dst_idx_q];
        amt_ext   = REG_WIDTH'(rq_amt_q);
        src_sum   = {1'b0, src_bal} + {1'b0, amt_ext};
        dst_sum   = {1'b0, dst_bal} + {1'b0, amt_ext};
        status_d  = ST_OK;
        src_bal_d = src_bal;
        dst_bal_d = dst_bal;
        wr_src    = 1'b0;
        wr_dst    = 1'b0;
        fail_clr  = 1'b0;
        fail_inc  = 1'b0;
        if (rq_op_q > OP_TRANSFER || (rq_op_q >= OP_DEPOSIT && rq_amt_q == '0) ||
            (rq_op_q == OP_TRANSFER && rq_dst_q == rq_acct_q)) begin
            status_d = ST_BAD_REQ;
        end else if (!src_hit_q) begin
            status_d = ST_NO_ACCT;
        end else if (rq_op_q == OP_LOOKUP) begin
            status_d = ST_OK;
        end else if (tbl_fail_q[src_idx_q] == FAIL_MAX) begin
            status_d = ST_LOCKED;
        end else if (tbl_pin_q[src_idx_q] != rq_pin_q) begin
            status_d = ST_BAD_PIN;
            fail_inc = 1'b1;
        end else begin
            fail_clr = 1'b1;
            case (rq_op_q)
                OP_DEPOSIT: begin
                    if (src_sum[REG_WIDTH]) status_d = ST_OVERFLOW;
                    else begin
                        src_bal_d = src_sum[REG_WIDTH-1:0];
                        wr_src    = 1'b1;
                    end
                end
                OP_WITHDRAW: begin
                    if (amt_ext > src_bal) status_d = ST_INSUFF;
                    else begin
                        src_bal_d = src_bal - amt_ext;
                        wr_src    = 1'b1;
                    end
                end
                OP_TRANSFER: begin
                    if (!dst_hit_q)              status_d = ST_NO_DST;
                    else if (amt_ext > src_bal)  status_d = ST_INSUFF;
                    else if (dst_sum[REG_WIDTH]) status_d = ST_OVERFLOW;
                    else begin
                        src_bal_d = src_bal - amt_ext;
                        dst_bal_d = dst_sum[REG_WIDTH-1:0];
                        wr_src    = 1'b1;
                        wr_dst    = 1'b1;
                    end
                end
                default: status_d = ST_OK;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            rq_op_q      <= '0;
            rq_acct_q    <= '0;
            rq_pin_q     <= '0;
            rq_dst_q     <= '0;
            rq_amt_q     <= '0;
            idx_q        <= '0;
            src_idx_q    <= '0;
            dst_idx_q    <= '0;
            src_hit_q    <= 1'b0;
            dst_hit_q    <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_status_q <= '0;
            rsp_bal_q    <= '0;
            rsp_dbal_q   <= '0;
            for (int i = 0; i < NUM_ACCTS; i++) begin
                tbl_vld_q[i]  <= 1'b0;
                tbl_acct_q[i] <= '0;
                tbl_pin_q[i]  <= '0;
                tbl_bal_q[i]  <= '0;
                tbl_fail_q[i] <= '0;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (init_we) begin
                        if (int'(init_idx) < NUM_ACCTS) begin
                            tbl_vld_q[init_idx]  <= 1'b1;
                            tbl_acct_q[init_idx] <= init_acct;
                            tbl_pin_q[init_idx]  <= init_pin;
                            tbl_bal_q[init_idx]  <= init_balance;
                            tbl_fail_q[init_idx] <= '0;
                        end
                    end else if (req_valid) begin
                        rq_op_q   <= req_op;
                        rq_acct_q <= req_acct;
                        rq_pin_q  <= req_pin;
                        rq_dst_q  <= req_dst;
                        rq_amt_q  <= req_amount;
                        idx_q     <= '0;
                        src_hit_q <= 1'b0;
                        dst_hit_q <= 1'b0;
                        state_q   <= S_SEARCH;
                    end
                end
                // Source and destination are matched in the same pass; first hit is kept.
                S_SEARCH: begin
                    if (!src_hit_q && tbl_vld_q[idx_q] && tbl_acct_q[idx_q] == rq_acct_q) begin
                        src_hit_q <= 1'b1;
                        src_idx_q <= idx_q;
                    end
                    if (!dst_hit_q && tbl_vld_q[idx_q] && tbl_acct_q[idx_q] == rq_dst_q) begin
                        dst_hit_q <= 1'b1;
                        dst_idx_q <= idx_q;
                    end
                    if (idx_q == LAST_IDX) state_q <= S_EXEC;
                    else                   idx_q   <= idx_q + 1'b1;
                end
                S_EXEC: begin
                    if (wr_src) tbl_bal_q[src_idx_q] <= src_bal_d;
                    if (wr_dst) tbl_bal_q[dst_idx_q] <= dst_bal_d;
                    if (fail_clr) tbl_fail_q[src_idx_q] <= '0;
                    else if (fail_inc && tbl_fail_q[src_idx_q] != 2'b11)
                        tbl_fail_q[src_idx_q] <= tbl_fail_q[src_idx_q] + 2'd1;
                    rsp_valid_q  <= 1'b1;
                    rsp_status_q <= status_d;
                    rsp_bal_q    <= src_hit_q ? src_bal_d : '0;
                    rsp_dbal_q   <= (rq_op_q == OP_TRANSFER && dst_hit_q) ? dst_bal_d : '0;
                    state_q      <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_atm_bank_responder.sv
// Table-driven bench for atm_bank_responder with a queue-based response scoreboard.
module tb_atm_bank_responder;

    typedef struct {
        logic [2:0]  op;
        logic [11:0] acct;
        logic [11:0] pin;
        logic [11:0] dst;
        logic [5:0]  amt;
        logic [2:0]  st;
        logic [11:0] bal;
        logic [11:0] dbal;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        init_we = 1'b0;
    logic [1:0]  init_idx = '0;
    logic [11:0] init_acct = '0, init_pin = '0, init_balance = '0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_op = '0;
    logic [11:0] req_acct = '0, req_pin = '0, req_dst = '0;
    logic [5:0]  req_amount = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [2:0]  rsp_status;
    logic [11:0] rsp_balance, rsp_dst_balance;

    int total = 0;
    int bad = 0;
    vec_t sb[$];

    atm_bank_responder #(.NUM_ACCTS(3), .REG_WIDTH(12), .AMT_WIDTH(6), .MAX_PIN_FAILS(3)) dut (
        .clk(clk), .rst(rst),
        .init_we(init_we), .init_idx(init_idx), .init_acct(init_acct),
        .init_pin(init_pin), .init_balance(init_balance),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_acct(req_acct), .req_pin(req_pin), .req_dst(req_dst), .req_amount(req_amount),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_status(rsp_status),
        .rsp_balance(rsp_balance), .rsp_dst_balance(rsp_dst_balance)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [2:0] op, input logic [11:0] acct, input logic [11:0] pin,
                                input logic [11:0] dst, input logic [5:0] amt, input logic [2:0] st,
                                input logic [11:0] bal, input logic [11:0] dbal);
        vec_t v;
        v.op = op; v.acct = acct; v.pin = pin; v.dst = dst; v.amt = amt;
        v.st = st; v.bal = bal; v.dbal = dbal;
        return v;
    endfunction

    task automatic load(input logic [1:0] idx, input logic [11:0] acct, input logic [11:0] pin,
                        input logic [11:0] bal);
        @(negedge clk);
        init_we = 1'b1; init_idx = idx; init_acct = acct; init_pin = pin; init_balance = bal;
        @(posedge clk);
        #1 init_we = 1'b0;
    endtask

    // Issue one request, expect the response NUM_ACCTS+2 edges later counting the accept edge.
    task automatic run(input vec_t v, input int hold);
        int cyc;
        int lat;
        vec_t e;
        sb.push_back(v);
        @(negedge clk);
        req_valid = 1'b1; req_op = v.op; req_acct = v.acct; req_pin = v.pin;
        req_dst = v.dst; req_amount = v.amt;
        cyc = 0;
        while (!req_ready && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 20) chk("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        lat = 1;
        #1 req_valid = 1'b0;
        while (!rsp_valid && lat < 40) begin
            @(posedge clk);
            lat++;
            #1;
        end
        chk("latency", lat, 5);
        @(negedge clk);
        e = sb.pop_front();
        chk("status", rsp_status, e.st);
        chk("balance", rsp_balance, e.bal);
        chk("dst_balance", rsp_dst_balance, e.dbal);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", rsp_valid, 1);
            chk("hold_status", rsp_status, e.st);
            chk("hold_balance", rsp_balance, e.bal);
            chk("hold_req_ready", req_ready, 0);
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        chk("rsp_drop", rsp_valid, 0);
    endtask

    vec_t t1[11];
    vec_t t2[5];

    initial begin
        // op: 0 LOOKUP 1 VERIFY 2 BALANCE 3 DEP 4 WD 5 TR; st: 0 OK 1 NO_ACCT 2 BAD_PIN 3 LOCKED 4 INSUF 5 NO_DST 6 OVF 7 BAD_REQ
        t1[0]  = mk(3'd4, 12'h123, 12'h111, 12'h000, 6'd20, 3'd0, 12'd30, 12'd0);
        t1[1]  = mk(3'd2, 12'h456, 12'h222, 12'h000, 6'd0,  3'd0, 12'd10, 12'd0);
        t1[2]  = mk(3'd3, 12'h456, 12'h222, 12'h000, 6'd0,  3'd7, 12'd10, 12'd0);
        t1[3]  = mk(3'd6, 12'h123, 12'h111, 12'h000, 6'd1,  3'd7, 12'd30, 12'd0);
        t1[4]  = mk(3'd5, 12'h123, 12'h111, 12'h456, 6'd30, 3'd0, 12'd0,  12'd40);
        t1[5]  = mk(3'd5, 12'h123, 12'h111, 12'h456, 6'd1,  3'd4, 12'd0,  12'd40);
        t1[6]  = mk(3'd5, 12'h456, 12'h222, 12'h789, 6'd5,  3'd5, 12'd40, 12'd0);
        t1[7]  = mk(3'd5, 12'h123, 12'h111, 12'h123, 6'd1,  3'd7, 12'd0,  12'd0);
        t1[8]  = mk(3'd4, 12'h999, 12'h111, 12'h000, 6'd5,  3'd1, 12'd0,  12'd0);
        t1[9]  = mk(3'd4, 12'h456, 12'h222, 12'h000, 6'd40, 3'd0, 12'd0,  12'd0);
        t1[10] = mk(3'd3, 12'h456, 12'h222, 12'h000, 6'd10, 3'd0, 12'd10, 12'd0);

        t2[0] = mk(3'd1, 12'h456, 12'h333, 12'h000, 6'd0, 3'd2, 12'd10, 12'd0);
        t2[1] = mk(3'd1, 12'h456, 12'h333, 12'h000, 6'd0, 3'd2, 12'd10, 12'd0);
        t2[2] = mk(3'd1, 12'h456, 12'h333, 12'h000, 6'd0, 3'd2, 12'd10, 12'd0);
        t2[3] = mk(3'd1, 12'h456, 12'h222, 12'h000, 6'd0, 3'd3, 12'd10, 12'd0);
        t2[4] = mk(3'd0, 12'h456, 12'h000, 12'h000, 6'd0, 3'd0, 12'd10, 12'd0);

        #12;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_status", rsp_status, 0);
        chk("rst_balance", rsp_balance, 0);
        chk("rst_dst_balance", rsp_dst_balance, 0);
        @(negedge clk);
        rst = 1'b0;

        load(2'd0, 12'h123, 12'h111, 12'd50);
        load(2'd1, 12'h456, 12'h222, 12'd10);
        for (int i = 0; i < 11; i++) run(t1[i], 0);

        // Deposit and transfer overflow against a near-full balance.
        load(2'd1, 12'h456, 12'h222, 12'hFD0);
        run(mk(3'd3, 12'h456, 12'h222, 12'h000, 6'd63, 3'd6, 12'hFD0, 12'd0), 0);
        run(mk(3'd3, 12'h123, 12'h111, 12'h000, 6'd63, 3'd0, 12'd63, 12'd0), 0);
        run(mk(3'd5, 12'h123, 12'h111, 12'h456, 6'd63, 3'd6, 12'd63, 12'hFD0), 0);

        load(2'd1, 12'h456, 12'h222, 12'd10);
        for (int i = 0; i < 5; i++) run(t2[i], 0);

        // Back-pressure: response held four cycles.
        run(mk(3'd2, 12'h123, 12'h111, 12'h000, 6'd0, 3'd0, 12'd63, 12'd0), 4);

        // Load and request in the same cycle: the load wins.
        @(negedge clk);
        init_we = 1'b1; init_idx = 2'd2; init_acct = 12'h789; init_pin = 12'h333; init_balance = 12'd5;
        req_valid = 1'b1; req_op = 3'd0; req_acct = 12'h789;
        #1 chk("init_blocks_ready", req_ready, 0);
        @(posedge clk);
        #1 init_we = 1'b0;
        run(mk(3'd0, 12'h789, 12'h000, 12'h000, 6'd0, 3'd0, 12'd5, 12'd0), 0);

        // Reset in the middle of a search aborts the withdraw and empties the table.
        @(negedge clk);
        req_valid = 1'b1; req_op = 3'd4; req_acct = 12'h123; req_pin = 12'h111; req_amount = 6'd10;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_rsp_valid", rsp_valid, 0);
        chk("abort_req_ready", req_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        run(mk(3'd0, 12'h123, 12'h000, 12'h000, 6'd0, 3'd1, 12'd0, 12'd0), 0);

        chk("scoreboard_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
